// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing for the RV32IM 5-stage core.
//   Detects load-use hazards that forwarding cannot cover. Runs the divide unit
//   through a start/done handshake, with a timeout. Flushes on taken
//   branches/jumps resolved in EX.
//
// Optional build macro: HAZARD_PERF_EN builds the performance counters.
//   When it is undefined, the counter outputs are tied to zero.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rs1_id, rs2_id, rs*_used_id      source operands of the instruction in ID
//   rd_ex, mem_read_ex, md_op_ex     destination and kind of the instruction in EX
//   md_done                          divide result valid (one-cycle pulse)
//   branch_taken_ex                  EX redirects the PC
//   stall_pc/if_id/id_ex             hold controls for the pipeline registers
//   flush_if_id/id_ex, bubble_ex_mem load a NOP into the register
//   md_start                         one-cycle divide launch pulse
//   md_error                         sticky divide timeout flag
//   load_stall_cnt, md_stall_cnt,
//   flush_cnt                        performance counters
module hazard_controller #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             md_op_ex,
    input  logic             md_done,
    input  logic             branch_taken_ex,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             bubble_ex_mem,
    output logic             md_start,
    output logic             md_error,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] md_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] TimeoutLast = 8'(MD_TIMEOUT - 1);

    typedef enum logic [0:0] {StRun, StMdWait} state_e;

    state_e     state_q, state_d;
    logic [7:0] tmo_q, tmo_d;
    logic       md_error_q, md_error_d;
    logic       load_use;
    logic       load_stall;
    logic       flush_evt;

    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rs1_used_id && (rs1_id == rd_ex)) ||
                       (rs2_used_id && (rs2_id == rd_ex)));

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        md_error_d    = md_error_q;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        bubble_ex_mem = 1'b0;
        md_start      = 1'b0;
        load_stall    = 1'b0;
        flush_evt     = 1'b0;

        case (state_q)
            StRun: begin
                // Priority: branch flush, then divide launch, then load-use stall.
                if (branch_taken_ex) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    flush_evt   = 1'b1;
                end else if (md_op_ex) begin
                    md_start      = 1'b1;
                    stall_pc      = 1'b1;
                    stall_if_id   = 1'b1;
                    stall_id_ex   = 1'b1;
                    bubble_ex_mem = 1'b1;
                    tmo_d         = 8'd0;
                    state_d       = StMdWait;
                end else if (load_use) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    load_stall  = 1'b1;
                end
            end
            StMdWait: begin
                // The release is combinational: the divide advances in the done
                // or abort cycle itself.
                if (md_done) begin
                    state_d = StRun;
                end else if (tmo_q == TimeoutLast) begin
                    md_error_d = 1'b1;
                    state_d    = StRun;
                end else begin
                    stall_pc      = 1'b1;
                    stall_if_id   = 1'b1;
                    stall_id_ex   = 1'b1;
                    bubble_ex_mem = 1'b1;
                    tmo_d         = tmo_q + 8'd1;
                end
            end
            default: state_d = StRun;
        endcase

        // The stage inputs may still look like a hazard while reset is held,
        // so the controls are forced quiet.
        if (!rst_n) begin
            stall_pc      = 1'b0;
            stall_if_id   = 1'b0;
            stall_id_ex   = 1'b0;
            flush_if_id   = 1'b0;
            flush_id_ex   = 1'b0;
            bubble_ex_mem = 1'b0;
            md_start      = 1'b0;
            load_stall    = 1'b0;
            flush_evt     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            tmo_q      <= 8'd0;
            md_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            md_error_q <= md_error_d;
        end
    end

    assign md_error = md_error_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] load_cnt_q, md_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q  <= '0;
            md_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load_stall)    load_cnt_q  <= load_cnt_q + CNT_W'(1);
            if (bubble_ex_mem) md_cnt_q    <= md_cnt_q + CNT_W'(1);
            if (flush_evt)     flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign load_stall_cnt = load_cnt_q;
    assign md_stall_cnt   = md_cnt_q;
    assign flush_cnt      = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf    = load_stall ^ flush_evt;
    assign load_stall_cnt = '0;
    assign md_stall_cnt   = '0;
    assign flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller (built with MD_TIMEOUT = 8).
module tb_hazard_controller;

    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    rs1_id, rs2_id, rd_ex;
    logic          rs1_used_id, rs2_used_id, mem_read_ex, md_op_ex, md_done, branch_taken_ex;
    logic          stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex;
    logic          bubble_ex_mem, md_start, md_error;
    logic [CW-1:0] load_stall_cnt, md_stall_cnt, flush_cnt;

    hazard_controller #(.MD_TIMEOUT(8), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs1_id         (rs1_id),
        .rs2_id         (rs2_id),
        .rs1_used_id    (rs1_used_id),
        .rs2_used_id    (rs2_used_id),
        .rd_ex          (rd_ex),
        .mem_read_ex    (mem_read_ex),
        .md_op_ex       (md_op_ex),
        .md_done        (md_done),
        .branch_taken_ex(branch_taken_ex),
        .stall_pc       (stall_pc),
        .stall_if_id    (stall_if_id),
        .stall_id_ex    (stall_id_ex),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .bubble_ex_mem  (bubble_ex_mem),
        .md_start       (md_start),
        .md_error       (md_error),
        .load_stall_cnt (load_stall_cnt),
        .md_stall_cnt   (md_stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    // Expected output word: {stall_pc, stall_if_id, stall_id_ex, flush_if_id,
    //                        flush_id_ex, bubble_ex_mem, md_start, md_error}
    typedef logic [7:0] exp_t;
    localparam exp_t Z   = 8'b0000_0000;
    localparam exp_t LD  = 8'b1100_1000;
    localparam exp_t BR  = 8'b0001_1000;
    localparam exp_t MDS = 8'b1110_0110;
    localparam exp_t MDW = 8'b1110_0100;
    localparam exp_t ERR = 8'b0000_0001;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       md;
        logic       done;
        logic       br;
    } in_t;

    typedef struct {
        in_t   i;
        exp_t  e;
        string name;
    } vec_t;

    typedef struct {
        exp_t  e;
        string name;
    } sb_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cnt_ld = 0, cnt_md = 0, cnt_fl = 0;
    sb_t  sb_q[$];
    sb_t  sb_cur;
    exp_t obs;
    vec_t tbl[11];

    assign obs = {stall_pc, stall_if_id, stall_id_ex, flush_if_id,
                  flush_id_ex, bubble_ex_mem, md_start, md_error};

    function automatic in_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic [4:0] rd, logic ld, logic md, logic done, logic br);
        in_t r;
        r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
        r.ld = ld; r.md = md; r.done = done; r.br = br;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must show.
    task automatic drive(input in_t i, input exp_t e, input string name);
        sb_t s;
        @(posedge clk);
        #1;
        rs1_id = i.rs1; rs2_id = i.rs2; rs1_used_id = i.u1; rs2_used_id = i.u2;
        rd_ex = i.rd; mem_read_ex = i.ld; md_op_ex = i.md; md_done = i.done;
        branch_taken_ex = i.br;
        s.e = e;
        s.name = name;
        sb_q.push_back(s);
        if (e[7] && e[3]) cnt_ld++;
        if (e[4]) cnt_fl++;
        if (e[2]) cnt_md++;
    endtask

    task automatic check_counters(input string tag);
`ifdef HAZARD_PERF_EN
        cmp({tag, " load_stall_cnt"}, load_stall_cnt, CW'(cnt_ld));
        cmp({tag, " md_stall_cnt"}, md_stall_cnt, CW'(cnt_md));
        cmp({tag, " flush_cnt"}, flush_cnt, CW'(cnt_fl));
`else
        cmp({tag, " load_stall_cnt"}, load_stall_cnt, '0);
        cmp({tag, " md_stall_cnt"}, md_stall_cnt, '0);
        cmp({tag, " flush_cnt"}, flush_cnt, '0);
`endif
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_cur = sb_q.pop_front();
            cmp(sb_cur.name, CW'(obs), CW'(sb_cur.e));
        end
    end

    initial begin
        in_t idle, div, div_done;
        idle     = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        div      = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        div_done = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);

        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), Z,  "idle"};
        tbl[1]  = '{mk(5, 0, 1, 0, 5, 1, 0, 0, 0), LD, "load-use rs1"};
        tbl[2]  = '{mk(0, 0, 1, 0, 0, 1, 0, 0, 0), Z,  "load rd x0"};
        tbl[3]  = '{mk(1, 7, 1, 1, 7, 1, 0, 0, 0), LD, "load-use rs2"};
        tbl[4]  = '{mk(9, 0, 0, 0, 9, 1, 0, 0, 0), Z,  "rs1 match unused"};
        tbl[5]  = '{mk(2, 9, 1, 0, 9, 1, 0, 0, 0), Z,  "rs2 match unused"};
        tbl[6]  = '{mk(5, 5, 1, 1, 5, 0, 0, 0, 0), Z,  "match not a load"};
        tbl[7]  = '{mk(5, 0, 1, 0, 5, 1, 0, 0, 1), BR, "branch over load-use"};
        tbl[8]  = '{mk(0, 0, 0, 0, 4, 0, 0, 0, 1), BR, "branch"};
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0), Z,  "md_done in run"};
        tbl[10] = '{mk(31, 31, 1, 1, 31, 1, 0, 0, 0), LD, "load-use both"};

        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; mem_read_ex = 1'b0;
        md_op_ex = 1'b0; md_done = 1'b0; branch_taken_ex = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        cmp("reset outputs", CW'(obs), CW'(Z));
        check_counters("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        foreach (tbl[k]) drive(tbl[k].i, tbl[k].e, tbl[k].name);

        // Divide, done at T+5; hazards during the wait are suppressed.
        drive(div, MDS, "div start");
        drive(div, MDW, "div wait 1");
        drive(mk(3, 0, 1, 0, 3, 1, 1, 0, 1), MDW, "div wait hazards masked");
        drive(div, MDW, "div wait 3");
        drive(div, MDW, "div wait 4");
        drive(div_done, Z, "div done release");
        drive(mk(5, 0, 1, 0, 5, 1, 0, 0, 0), LD, "run after div");

        // Minimum divide: done at T+1.
        drive(div, MDS, "short div start");
        drive(div_done, Z, "short div done");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), Z, "stray done in run");
        drive(idle, Z, "idle before counters");
        @(negedge clk);
        #2;
        check_counters("after divides");

        // Timeout: 7 stalled wait cycles, abort on the 8th, sticky error.
        drive(div, MDS, "timeout div start");
        for (int k = 0; k < 7; k++) drive(div, MDW, "timeout wait");
        drive(div, Z, "timeout abort");
        drive(idle, ERR, "error sticky idle");
        drive(mk(5, 0, 1, 0, 5, 1, 0, 0, 0), LD | ERR, "load-use after abort");
        drive(div, MDS | ERR, "div after abort");
        drive(div_done, ERR, "div done after abort");

        // Reset in the middle of a divide.
        drive(div, MDS | ERR, "rst div start");
        drive(div, MDW | ERR, "rst div wait");
        drive(div, Z, "rst asserted");
        rst_n = 1'b0;
        cnt_ld = 0; cnt_md = 0; cnt_fl = 0;
        drive(idle, Z, "rst released");
        rst_n = 1'b1;
        drive(mk(5, 0, 1, 0, 5, 1, 0, 0, 0), LD, "load-use after reset");
        drive(idle, Z, "idle end");
        @(negedge clk);
        #2;
        check_counters("after reset");
        cmp("scoreboard drained", CW'(sb_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
